ahb_master: RTL

AHB-Lite bus initiator that turns simple command-port requests into single or incrementing-burst AHB transfers on the shared memory bus. It drives address and control for the memory slave and any other slaves on the bus. It overlaps each address phase with the previous data phase, stretches on HREADY wait states, and aborts a burst cleanly on an ERROR response. It sits between the DMA/CPU request logic and the bus decoder.

---
 rtl/ahb_pkg.sv | 28 ++
 rtl/ahb_burst_addr_gen.sv | 53 +++++
 rtl/ahb_master.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the bus initiator and the memory slave.
package ahb_pkg;

   typedef enum logic [1:0] {
      TransIdle   = 2'b00,
      TransBusy   = 2'b01,
      TransNonseq = 2'b10,
      TransSeq    = 2'b11
   } htrans_t;

   localparam logic [2:0] BurstSingle = 3'b000;
   localparam logic [2:0] BurstIncr   = 3'b001;

   localparam logic [2:0] SizeByte = 3'b000;
   localparam logic [2:0] SizeHalf = 3'b001;
   localparam logic [2:0] SizeWord = 3'b010;

   localparam logic [1:0] RespOkay  = 2'b00;
   localparam logic [1:0] RespError = 2'b01;

   typedef enum logic [1:0] {
      StIdle,
      StAddr,
      StData,
      StErr
   } mst_state_t;

endpackage

// File: rtl/ahb_burst_addr_gen.sv
// Burst address register, size-scaled increment, beat counter and 1 KB boundary detect.
module ahb_burst_addr_gen
   import ahb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              load,
   input  logic              advance,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [3:0]        load_len,
   input  logic [2:0]        size,
   output logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] next_addr,
   output logic              last_beat,
   output logic              boundary
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [4:0]        count_q, count_d;

   assign addr      = addr_q;
   assign next_addr = addr_q + (ADDR_W'(1) << size);
   assign last_beat = (count_q == 5'd1);
   // A new 1 KB page must restart with NONSEQ.
   assign boundary  = (next_addr[9:0] == 10'd0);

   always_comb begin
      addr_d  = addr_q;
      count_d = count_q;
      if (load) begin
         addr_d  = load_addr;
         count_d = {1'b0, load_len} + 5'd1;
      end else if (advance) begin
         count_d = count_q - 5'd1;
         if (!last_beat) begin
            addr_d = next_addr;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_q  <= '0;
         count_q <= '0;
      end else begin
         addr_q  <= addr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/ahb_master.sv
// AHB-Lite initiator: command port to single/INCR bursts with pipelined address/data phases.
module ahb_master
   import ahb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_size,
   input  logic [3:0]        req_len,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [DATA_W-1:0] HWDATA,
   input  logic [DATA_W-1:0] HRDATA,
   input  logic              HREADY,
   input  logic [1:0]        HRESP
);

   mst_state_t        state_q, state_d;
   htrans_t           htrans_q, htrans_d;
   logic              hwrite_q, hwrite_d;
   logic [2:0]        hsize_q, hsize_d;
   logic [2:0]        hburst_q, hburst_d;
   logic [DATA_W-1:0] hwdata_q, hwdata_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              pend_q, pend_d;  // a data phase is outstanding on the bus

   logic              load, advance, last_beat, boundary, err_first;
   logic [ADDR_W-1:0] next_addr;
   logic              unused_hresp;

   assign unused_hresp = HRESP[1];

   ahb_burst_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .load      (load),
      .advance   (advance),
      .load_addr (req_addr),
      .load_len  (req_len),
      .size      (hsize_q),
      .addr      (HADDR),
      .next_addr (next_addr),
      .last_beat (last_beat),
      .boundary  (boundary)
   );

   assign err_first = pend_q && !HREADY && HRESP[0];
   assign req_ready = (state_q == StIdle);

   always_comb begin
      state_d    = state_q;
      htrans_d   = htrans_q;
      hwrite_d   = hwrite_q;
      hsize_d    = hsize_q;
      hburst_d   = hburst_q;
      hwdata_d   = hwdata_q;
      rd_data_d  = rd_data_q;
      pend_d     = pend_q;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      load       = 1'b0;
      advance    = 1'b0;
      wr_ready   = 1'b0;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               load     = 1'b1;
               htrans_d = TransNonseq;
               hwrite_d = req_write;
               hsize_d  = req_size;
               hburst_d = (req_len == 4'd0) ? BurstSingle : BurstIncr;
               pend_d   = 1'b0;
               state_d  = StAddr;
            end
         end
         StAddr: begin
            if (err_first) begin
               htrans_d = TransIdle;
               pend_d   = 1'b0;
               state_d  = StErr;
            end else if (HREADY) begin
               // Address accepted; the previous beat's data phase completes on the same edge.
               advance = 1'b1;
               if (hwrite_q) begin
                  hwdata_d = wr_data;
                  wr_ready = 1'b1;
               end else if (pend_q) begin
                  rd_data_d  = HRDATA;
                  rd_valid_d = 1'b1;
               end
               pend_d = 1'b1;
               if (last_beat) begin
                  htrans_d = TransIdle;
                  state_d  = StData;
               end else begin
                  htrans_d = boundary ? TransNonseq : TransSeq;
               end
            end
         end
         StData: begin
            if (err_first) begin
               htrans_d = TransIdle;
               pend_d   = 1'b0;
               state_d  = StErr;
            end else if (HREADY) begin
               if (!hwrite_q) begin
                  rd_data_d  = HRDATA;
                  rd_valid_d = 1'b1;
               end
               done_d  = 1'b1;
               pend_d  = 1'b0;
               state_d = StIdle;
            end
         end
         StErr: begin
            if (HREADY) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= StIdle;
         htrans_q   <= TransIdle;
         hwrite_q   <= 1'b0;
         hsize_q    <= '0;
         hburst_q   <= '0;
         hwdata_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         htrans_q   <= htrans_d;
         hwrite_q   <= hwrite_d;
         hsize_q    <= hsize_d;
         hburst_q   <= hburst_d;
         hwdata_q   <= hwdata_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
         err_q      <= err_d;
         pend_q     <= pend_d;
      end
   end

   assign HTRANS   = htrans_q;
   assign HWRITE   = hwrite_q;
   assign HSIZE    = hsize_q;
   assign HBURST   = hburst_q;
   assign HWDATA   = hwdata_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule
